// File: rtl/fp_types.sv
// rtl/fp_types.sv - shared FP types, NaN constants and op-decode helpers for the sign-injection issue stage
package fp_types;

    localparam logic [1:0]  FMT_S           = 2'd0;
    localparam logic [1:0]  FMT_D           = 2'd1;
    localparam logic [31:0] CANON_NAN_S     = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_BOXED = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [63:0] CANON_NAN_UNBOX = {32'h0000_0000, CANON_NAN_S};

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_sgnj_in_type;

    typedef struct packed {
        logic [63:0] result;
    } fp_sgnj_out_type;

    // Only single/double formats and the three sign-injection variants exist.
    function automatic logic is_illegal_op(input logic [1:0] fmt, input logic [2:0] rm);
        return (fmt > FMT_D) || (rm > 3'd2);
    endfunction

    function automatic logic [63:0] unbox_operand(input logic [1:0] fmt, input logic [63:0] data);
        if (fmt == FMT_S && data[63:32] != 32'hFFFF_FFFF)
            return CANON_NAN_UNBOX;
        return data;
    endfunction

endpackage

// File: rtl/fp_sgnj_issue_if.sv
// rtl/fp_sgnj_issue_if.sv - push/pop interface between the issue stage and its op queue
interface fp_issue_fifo_if #(parameter int W = 8);
    logic         clear;
    logic         push;
    logic         pop;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         empty;
    logic         full;

    modport master (output clear, push, pop, wdata, input rdata, empty, full);
    modport slave  (input clear, push, pop, wdata, output rdata, empty, full);
endinterface

// File: rtl/fp_issue_fifo.sv
// rtl/fp_issue_fifo.sv - DEPTH-entry op queue with wrapping pointers and an occupancy count
module fp_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    fp_issue_fifo_if.slave  q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign q.empty = (count == '0);
    assign q.full  = (count == CW'(DEPTH));
    assign q.rdata = mem[rptr];

    // Local guards keep the queue safe even if the producer misbehaves.
    assign do_pop  = q.pop && !q.empty;
    assign do_push = q.push && (!q.full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (q.clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !q.clear) mem[wptr] <= q.wdata;
    end

endmodule

// File: rtl/fp_sgnj_issue.sv
// rtl/fp_sgnj_issue.sv - queues sign-injection ops, feeds the external unit and registers the boxed result
module fp_sgnj_issue
    import fp_types::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data1,
    input  logic [63:0]      in_data2,
    input  logic [1:0]       in_fmt,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output fp_sgnj_in_type   sgnj_req,
    input  fp_sgnj_out_type  sgnj_rsp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int ENTRY_W = 64 + 64 + 2 + 3 + TAG_W;

    fp_issue_fifo_if #(.W(ENTRY_W)) q ();

    logic [63:0]      h_data1;
    logic [63:0]      h_data2;
    logic [1:0]       h_fmt;
    logic [2:0]       h_rm;
    logic [TAG_W-1:0] h_tag;
    logic             h_illegal;
    logic             pop;

    fp_issue_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk (clk),
        .rst (rst),
        .q   (q.slave)
    );

    assign pop      = !q.empty && (!out_valid || out_ready);
    assign in_ready = !q.full || pop;

    assign q.clear = flush;
    assign q.push  = in_valid && in_ready && !flush;
    assign q.pop   = pop && !flush;
    assign q.wdata = {in_tag, in_rm, in_fmt, in_data2, in_data1};

    assign {h_tag, h_rm, h_fmt, h_data2, h_data1} = q.rdata;
    assign h_illegal = is_illegal_op(h_fmt, h_rm);

    always_comb begin
        sgnj_req = '0;
        if (!q.empty) begin
            sgnj_req.data1 = unbox_operand(h_fmt, h_data1);
            sgnj_req.data2 = unbox_operand(h_fmt, h_data2);
            sgnj_req.fmt   = h_fmt;
            sgnj_req.rm    = h_rm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
        end else if (q.pop) begin
            out_valid   <= 1'b1;
            out_tag     <= h_tag;
            out_illegal <= h_illegal;
            if (h_illegal)
                out_result <= '0;
            else if (h_fmt == FMT_S)
                out_result <= {32'hFFFF_FFFF, sgnj_rsp.result[31:0]};
            else
                out_result <= sgnj_rsp.result;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_sgnj_issue.sv
// tb/tb_fp_sgnj_issue.sv - scoreboard bench for the sign-injection issue stage
module tb_fp_sgnj_issue;
    import fp_types::*;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data1;
    logic [63:0]      in_data2;
    logic [1:0]       in_fmt;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_tag;
    fp_sgnj_in_type   sgnj_req;
    fp_sgnj_out_type  sgnj_rsp;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_sgnj_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data1    (in_data1),
        .in_data2    (in_data2),
        .in_fmt      (in_fmt),
        .in_rm       (in_rm),
        .in_tag      (in_tag),
        .sgnj_req    (sgnj_req),
        .sgnj_rsp    (sgnj_rsp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    // Stand-in sign-injection unit: returns an unboxed single result so the DUT must do the boxing.
    logic sa, sbit, snew;
    always_comb begin
        sa       = (sgnj_req.fmt == 2'd1) ? sgnj_req.data1[63] : sgnj_req.data1[31];
        sbit     = (sgnj_req.fmt == 2'd1) ? sgnj_req.data2[63] : sgnj_req.data2[31];
        case (sgnj_req.rm)
            3'd0:    snew = sbit;
            3'd1:    snew = ~sbit;
            3'd2:    snew = sa ^ sbit;
            default: snew = ~sa;
        endcase
        if (sgnj_req.fmt == 2'd1)
            sgnj_rsp.result = {snew, sgnj_req.data1[62:0]};
        else
            sgnj_rsp.result = {sgnj_req.data1[63:32], snew, sgnj_req.data1[30:0]};
    end

    function automatic exp_t model(input logic [63:0] d1, input logic [63:0] d2,
                                   input logic [1:0] f, input logic [2:0] r, input logic [TAG_W-1:0] t);
        exp_t e;
        logic [31:0] a, b;
        logic s;
        e.tag = t;
        e.ill = (f > 2'd1) || (r > 3'd2);
        e.res = 64'd0;
        if (!e.ill) begin
            if (f == 2'd1) begin
                s = (r == 3'd0) ? d2[63] : (r == 3'd1) ? ~d2[63] : (d1[63] ^ d2[63]);
                e.res = {s, d1[62:0]};
            end else begin
                a = (d1[63:32] == 32'hFFFF_FFFF) ? d1[31:0] : 32'h7FC0_0000;
                b = (d2[63:32] == 32'hFFFF_FFFF) ? d2[31:0] : 32'h7FC0_0000;
                s = (r == 3'd0) ? b[31] : (r == 3'd1) ? ~b[31] : (a[31] ^ b[31]);
                e.res = {32'hFFFF_FFFF, s, a[30:0]};
            end
        end
        return e;
    endfunction

    // Drivers change inputs at negedge+1; this samples at negedge+3, i.e. the values the next posedge sees.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output tag=%0d result=%h", out_tag, out_result);
                end else begin
                    e = sb.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || out_illegal !== e.ill)
                        $display("FAIL scoreboard got res=%h tag=%0d ill=%b want res=%h tag=%0d ill=%b",
                                 out_result, out_tag, out_illegal, e.res, e.tag, e.ill);
                    else
                        passes++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_data1, in_data2, in_fmt, in_rm, in_tag));
        end
    end

    // Call at negedge+1; returns at negedge+1 after the accepting edge.
    task automatic send(input logic [63:0] d1, input logic [63:0] d2, input logic [1:0] f,
                        input logic [2:0] r, input logic [TAG_W-1:0] t, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_data1 = d1;
        in_data2 = d2;
        in_fmt   = f;
        in_rm    = r;
        in_tag   = t;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (in_ready) begin
                @(negedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
            @(negedge clk); #1;
        end
        checks++;
        $display("FAIL send_timeout tag=%0d in_ready=%b required=1", t, in_ready);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(negedge clk); #1;
        end
        checks++;
        if (sb.size() != 0 || out_valid)
            $display("FAIL %s_drain pending=%0d out_valid=%b required 0/0", name, sb.size(), out_valid);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data1 = '0; in_data2 = '0; in_fmt = '0; in_rm = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_result !== 64'd0) $display("FAIL reset_out_result got %h want 0", out_result); else passes++;
        checks++; if (out_tag !== '0) $display("FAIL reset_out_tag got %0d want 0", out_tag); else passes++;
        checks++; if (out_illegal !== 1'b0) $display("FAIL reset_out_illegal got %b want 0", out_illegal); else passes++;
        checks++; if (sgnj_req !== '0) $display("FAIL reset_sgnj_req got %h want 0", sgnj_req); else passes++;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
    endtask

    task automatic test_single();
        int st;
        send(64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 3'd0, 5'd3, st);
        checks++; if (out_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", out_valid); else passes++;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1) $display("FAIL single_latency got %b want 1", out_valid); else passes++;
        checks++; if (out_result !== 64'hBFF0_0000_0000_0000)
            $display("FAIL single_result got %h want bff0000000000000", out_result); else passes++;
        drain("single");
    endtask

    task automatic test_unbox();
        int st;
        send(64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_8000_0000, 2'd0, 3'd2, 5'd4, st);
        checks++; if (sgnj_req.data1 !== 64'h0000_0000_7FC0_0000)
            $display("FAIL unbox_req_data1 got %h want 000000007fc00000", sgnj_req.data1); else passes++;
        checks++; if (sgnj_req.data2 !== 64'hFFFF_FFFF_8000_0000)
            $display("FAIL unbox_req_data2 got %h want ffffffff80000000", sgnj_req.data2); else passes++;
        @(negedge clk); #1;
        checks++; if (out_result !== 64'hFFFF_FFFF_FFC0_0000)
            $display("FAIL unbox_result got %h want ffffffffffc00000", out_result); else passes++;
        drain("unbox");
    endtask

    task automatic test_illegal();
        int st;
        send(64'h4000_0000_0000_0000, 64'h8000_0000_0000_0001, 2'd2, 3'd0, 5'd7, st);
        @(negedge clk); #1;
        checks++; if (out_illegal !== 1'b1 || out_result !== 64'd0 || out_tag !== 5'd7)
            $display("FAIL illegal_fmt got ill=%b res=%h tag=%0d want 1/0/7", out_illegal, out_result, out_tag);
        else passes++;
        send(64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 3'd5, 5'd9, st);
        send(64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 3'd1, 5'd10, st);
        drain("illegal");
    endtask

    task automatic test_backpressure();
        int st;
        logic [63:0] hold_res;
        logic [TAG_W-1:0] hold_tag;
        out_ready = 1'b0;
        send(64'h3FF0_0000_0000_0000, 64'h0, 2'd1, 3'd1, 5'd1, st);
        send(64'hC000_0000_0000_0000, 64'h0, 2'd1, 3'd0, 5'd2, st);
        send(64'hFFFF_FFFF_4049_0FDB, 64'hFFFF_FFFF_8000_0000, 2'd0, 3'd0, 5'd3, st);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd1)
            $display("FAIL bp_head got valid=%b tag=%0d want 1/1", out_valid, out_tag); else passes++;
        hold_res = out_result;
        hold_tag = out_tag;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== hold_res || out_tag !== hold_tag || in_ready !== 1'b0)
            $display("FAIL bp_stable got valid=%b res=%h tag=%0d rdy=%b want 1/%h/%0d/0",
                     out_valid, out_result, out_tag, in_ready, hold_res, hold_tag);
        else passes++;
        out_ready = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_back_to_back();
        int st, total;
        logic [63:0] d1, d2;
        logic [1:0]  f;
        total = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f  = 2'($urandom_range(0, 1));
            d1 = {$urandom, $urandom};
            d2 = {$urandom, $urandom};
            if (f == 2'd0 && $urandom_range(0, 1) == 1) d1[63:32] = 32'hFFFF_FFFF;
            if (f == 2'd0 && $urandom_range(0, 1) == 1) d2[63:32] = 32'hFFFF_FFFF;
            send(d1, d2, f, 3'($urandom_range(0, 2)), 5'(16 + i), st);
            total += st;
        end
        checks++; if (total != 0) $display("FAIL b2b_stalls got %0d want 0", total); else passes++;
        drain("back_to_back");
    endtask

    task automatic test_flush();
        int st;
        out_ready = 1'b0;
        send(64'h1, 64'h0, 2'd1, 3'd0, 5'd11, st);
        send(64'h2, 64'h0, 2'd1, 3'd0, 5'd12, st);
        send(64'h3, 64'h0, 2'd1, 3'd0, 5'd13, st);
        flush = 1'b1;
        in_valid = 1'b1; in_data1 = 64'h4; in_fmt = 2'd1; in_rm = 3'd0; in_tag = 5'd14;
        @(negedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sgnj_req !== '0)
            $display("FAIL flush_clear got valid=%b rdy=%b req=%h want 0/1/0", out_valid, in_ready, sgnj_req);
        else passes++;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_reset_mid();
        int st;
        out_ready = 1'b0;
        send(64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 3'd0, 5'd21, st);
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre got %b want 1", out_valid); else passes++;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== '0)
            $display("FAIL rstmid_async got valid=%b res=%h tag=%0d want 0/0/0", out_valid, out_result, out_tag);
        else passes++;
        @(negedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_stale got %b want 0", out_valid); else passes++;
        send(64'h4000_0000_0000_0000, 64'h0, 2'd1, 3'd1, 5'd22, st);
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_unbox();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
